// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences multi-cycle mult/div ops and raises the D-stage MD stall.
// Build option MDU_DIVZERO_KEEP_EN: div/divu with B=0 never start and leave HI/LO untouched.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [3:0]  MDUSel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_IsMD,
  output logic        Start,
  output logic        Busy,
  output logic        Stall_MD,
  output logic [31:0] Q,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [CW-1:0] cnt;
  logic [31:0]   hi_q, lo_q, p_hi, p_lo;
  logic [31:0]   res_hi, res_lo;
  logic          is_mul, is_div, div_zero, op_start;

  logic signed [63:0] a_s64, b_s64, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s, rem_s;

  assign is_mul   = (MDUSel == OP_MULT) || (MDUSel == OP_MULTU);
  assign is_div   = (MDUSel == OP_DIV)  || (MDUSel == OP_DIVU);
  assign div_zero = is_div && (B == 32'd0);

`ifdef MDU_DIVZERO_KEEP_EN
  assign op_start = is_mul || (is_div && !div_zero);
`else
  assign op_start = is_mul || is_div;
`endif

  assign Busy     = (cnt != '0);
  assign Start    = op_start && !Busy;
  assign Stall_MD = D_IsMD && (Start || Busy);
  assign HI       = hi_q;
  assign LO       = lo_q;

  always_comb begin
    Q = 32'd0;
    if (MDUSel == OP_MFHI)      Q = hi_q;
    else if (MDUSel == OP_MFLO) Q = lo_q;
  end

  // Sign-extend to 64 bits first so the signed product keeps its upper half.
  assign a_s64  = $signed(A);
  assign b_s64  = $signed(B);
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'd0, A} * {32'd0, B};

  always_comb begin
    quot_s = 32'sd0;
    rem_s  = 32'sd0;
    if (B != 32'd0) begin
      quot_s = $signed(A) / $signed(B);
      rem_s  = $signed(A) % $signed(B);
    end
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (div_zero) begin
      res_hi = A;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      case (MDUSel)
        OP_MULT:  {res_hi, res_lo} = prod_s;
        OP_MULTU: {res_hi, res_lo} = prod_u;
        OP_DIV: begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
        OP_DIVU: begin
          res_hi = A % B;
          res_lo = A / B;
        end
        default: ;
      endcase
    end
  end

  // Result is captured at Start and held in p_hi/p_lo until the count expires.
  always_ff @(posedge clk) begin
    if (RESET) begin
      cnt  <= '0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      p_hi <= 32'd0;
      p_lo <= 32'd0;
    end else if (Busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        hi_q <= p_hi;
        lo_q <= p_lo;
      end
    end else if (Start) begin
      p_hi <= res_hi;
      p_lo <= res_lo;
      cnt  <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (MDUSel == OP_MTHI) begin
      hi_q <= A;
    end else if (MDUSel == OP_MTLO) begin
      lo_q <= A;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with default cycle counts (5 mult / 10 div).
// Honours MDU_DIVZERO_KEEP_EN for the divide-by-zero expectations.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  MDUSel;
  logic [31:0] A, B;
  logic        D_IsMD;
  logic        Start, Busy, Stall_MD;
  logic [31:0] Q, HI, LO;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .RESET    (RESET),
    .MDUSel   (MDUSel),
    .A        (A),
    .B        (B),
    .D_IsMD   (D_IsMD),
    .Start    (Start),
    .Busy     (Busy),
    .Stall_MD (Stall_MD),
    .Q        (Q),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle, then idles E until Busy drops (bounded).
  // Returns in the first cycle with Busy=0, with MDUSel=0 already applied.
  task automatic run_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, output int nbusy, output int nstall,
                        output logic started);
    MDUSel = sel; A = a; B = b; D_IsMD = dmd;
    #1;
    started = Start;
    nstall  = Stall_MD ? 1 : 0;
    nbusy   = 0;
    step();
    MDUSel = 4'd0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (Stall_MD) nstall++;
      if (!Busy) break;
      nbusy++;
      step();
    end
  endtask

  int   nb, ns;
  logic st;

  initial begin
    RESET = 1'b1; MDUSel = 4'd0; A = 32'd0; B = 32'd0; D_IsMD = 1'b0;
    step(); step();
    RESET = 1'b0;
    #1;
    check_eq("reset_hi", HI, 32'd0);
    check_eq("reset_lo", LO, 32'd0);
    check_eq("reset_busy", {31'd0, Busy}, 32'd0);
    D_IsMD = 1'b1; MDUSel = 4'd1; #1;
    check_eq("reset_stall_comb", {31'd0, Stall_MD}, 32'd1);
    MDUSel = 4'd0; #1;
    check_eq("idle_stall", {31'd0, Stall_MD}, 32'd0);
    D_IsMD = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, ns, st);
    check_eq("mult_start", {31'd0, st}, 32'd1);
    check_eq("mult_busy_n", nb, 32'd5);
    check_eq("mult_hi", HI, 32'hFFFF_FFFF);
    check_eq("mult_lo", LO, 32'hFFFF_FFFE);

    // issued immediately in the first idle cycle: no dead cycle expected
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, nb, ns, st);
    check_eq("multu_start", {31'd0, st}, 32'd1);
    check_eq("multu_busy_n", nb, 32'd5);
    check_eq("multu_hi", HI, 32'd1);
    check_eq("multu_lo", LO, 32'hFFFF_FFFE);

    run_op(4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, nb, ns, st);
    check_eq("mult_negneg_hi", HI, 32'd0);
    check_eq("mult_negneg_lo", LO, 32'd15);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns, st);
    check_eq("div_busy_n", nb, 32'd10);
    check_eq("div_stall_n_nodmd", ns, 32'd0);
    check_eq("div_lo", LO, 32'hFFFF_FFFD);
    check_eq("div_hi", HI, 32'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd2, 1'b0, nb, ns, st);
    check_eq("divu_busy_n", nb, 32'd10);
    check_eq("divu_lo", LO, 32'd3);
    check_eq("divu_hi", HI, 32'd1);

    run_op(4'd3, 32'd100, 32'd7, 1'b1, nb, ns, st);
    check_eq("div_stall_n", ns, 32'd11);
    MDUSel = 4'd6; #1;
    check_eq("mflo_after_div", Q, 32'd14);
    check_eq("mflo_no_stall", {31'd0, Stall_MD}, 32'd0);
    MDUSel = 4'd5; #1;
    check_eq("mfhi_after_div", Q, 32'd2);
    step();

    MDUSel = 4'd7; A = 32'h1234_5678; D_IsMD = 1'b1; #1;
    check_eq("mthi_no_stall", {31'd0, Stall_MD}, 32'd0);
    step();
    MDUSel = 4'd5; A = 32'd0; #1;
    check_eq("mfhi_after_mthi", Q, 32'h1234_5678);
    step();
    MDUSel = 4'd8; A = 32'hCAFE_0001; #1;
    step();
    MDUSel = 4'd6; A = 32'd0; #1;
    check_eq("mflo_after_mtlo", Q, 32'hCAFE_0001);
    MDUSel = 4'd9; #1;
    check_eq("q_other_op", Q, 32'd0);
    step();
    D_IsMD = 1'b0;

    run_op(4'd3, 32'd5, 32'd0, 1'b0, nb, ns, st);
`ifdef MDU_DIVZERO_KEEP_EN
    check_eq("divz_busy_n", nb, 32'd0);
    check_eq("divz_hi", HI, 32'h1234_5678);
    check_eq("divz_lo", LO, 32'hCAFE_0001);
`else
    check_eq("divz_busy_n", nb, 32'd10);
    check_eq("divz_hi", HI, 32'd5);
    check_eq("divz_lo", LO, 32'hFFFF_FFFF);
`endif

    MDUSel = 4'd1; A = 32'd3; B = 32'd4; #1;
    check_eq("rst_mult_start", {31'd0, Start}, 32'd1);
    step();
    MDUSel = 4'd0;
    step();
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0; #1;
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_hi", HI, 32'd0);
    check_eq("rst_lo", LO, 32'd0);
    repeat (8) step();
    check_eq("rst_no_wb_lo", LO, 32'd0);
    check_eq("rst_no_wb_busy", {31'd0, Busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
